irq_ctrl: RTL

Parametrised interrupt controller replacing the single-line CP0 interrupt path of the single-cycle MIPS core. Latches edge-triggered requests on `NUM_IRQ` lines, masks and prioritises them, supports nested preemption through an EPC stack of depth `NEST_DEPTH`, and drives the PC redirect and writeback-squash signals consumed by the PC calculator, register file and data memory. PC values are word addresses: the next sequential PC is `current_pc+1`.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/epc_stack.sv | 56 +++++
 rtl/irq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Purpose: shared types and helpers for the interrupt controller (EPC stack entry, vector address).
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package irq_pkg;

  // Stack entries are sized for the widest supported configuration:
  // PC up to 32 bits and up to 32 interrupt lines.
  localparam int EPC_W = 32;
  localparam int LVL_W = 5;

  typedef struct packed {
    logic [EPC_W-1:0] epc;    // PC of the squashed instruction, re-executed on return
    logic [LVL_W-1:0] level;  // priority that was in service before this entry was pushed
  } stk_ent_t;

  // Vector address of interrupt line idx.
  function automatic logic [EPC_W-1:0] vec_addr(input logic [EPC_W-1:0] base,
                                                input logic [EPC_W-1:0] stride,
                                                input logic [LVL_W-1:0] idx);
    return base + stride * EPC_W'(idx);
  endfunction

endpackage

// File: rtl/epc_stack.sv
// Purpose: parametrised LIFO holding return state for nested interrupts.
// Latency: push/pop take effect at the clock edge; top/count/full are registered-state outputs.
// Backpressure: push while full and pop while empty are ignored; caller checks full/count.
//
// Ports: clk, clr_n (async active-low reset), push/pop strobes, din (entry to push),
//        top (most recent entry, 0 when empty), count (entries held), full.
module epc_stack #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, rd_idx;

  // count never reaches DEPTH on a write (guarded by full), so truncation is safe
  assign wr_idx = IW'(cnt_q);
  assign rd_idx = IW'(cnt_q - CW'(1));
  assign full   = (cnt_q == CW'(DEPTH));
  assign count  = cnt_q;
  assign top    = (cnt_q == '0) ? '0 : mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      cnt_d         = cnt_q + CW'(1);
    end else if (pop && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Purpose: edge-latched, masked, prioritised interrupt controller with nested preemption (EPC stack).
// Latency: edge sampled at edge N -> pending after N -> redirect combinational in cycle N+1; ERET redirect same cycle.
// Backpressure: none on inputs; when the stack is full requests simply stay pending.
//
// Ports: clk, clr_n (async active-low); irq lines; current_pc; eret; mask_we/mask_wdata;
//        pc_jump/pc_addr/writeback_mask/interrupt (combinational redirect); pending, depth, epc, eret_err.
// Build option: define IRQ_CTRL_NEST_EN for nested preemption with NEST_DEPTH entries;
//        without it a single EPC register is used and only one interrupt is in service at a time.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ    = 8,
  parameter int                 NEST_DEPTH = 4,
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = 'h100,
  parameter int                 VEC_STRIDE = 4,
  parameter logic [NUM_IRQ-1:0] MASK_RST   = '1
) (
  input  logic                            clk,
  input  logic                            clr_n,
  input  logic [NUM_IRQ-1:0]              irq,
  input  logic [ADDR_W-1:0]               current_pc,
  input  logic                            eret,
  input  logic                            mask_we,
  input  logic [NUM_IRQ-1:0]              mask_wdata,
  output logic                            pc_jump,
  output logic [ADDR_W-1:0]               pc_addr,
  output logic                            writeback_mask,
  output logic                            interrupt,
  output logic [NUM_IRQ-1:0]              pending,
  output logic [$clog2(NEST_DEPTH+1)-1:0] depth,
  output logic [ADDR_W-1:0]               epc,
  output logic                            eret_err
);
  localparam int SW = $clog2(NUM_IRQ);
  localparam int DW = $clog2(NEST_DEPTH+1);
`ifdef IRQ_CTRL_NEST_EN
  localparam int EFF_DEPTH = NEST_DEPTH;
`else
  localparam int EFF_DEPTH = 1;
`endif
  localparam int CW = $clog2(EFF_DEPTH+1);

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [SW-1:0]      level_q, level_d;
  logic               err_q, err_d;

  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [SW-1:0]      sel;
  logic               any_elig;
  logic               preempt_ok;
  logic               take;
  logic               ret;

  stk_ent_t           stk_din, stk_top;
  logic [CW-1:0]      stk_cnt;
  logic               stk_full;

  assign elig = pend_q & mask_q;

  // Lowest eligible index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (elig[i]) begin
        sel      = SW'(i);
        any_elig = 1'b1;
      end
    end
  end

`ifdef IRQ_CTRL_NEST_EN
  assign preempt_ok = (stk_cnt == '0) || (sel < level_q);
`else
  assign preempt_ok = 1'b1;  // stack of one: full already blocks any second take
`endif

  assign take = any_elig && !stk_full && preempt_ok;
  // take has priority: an ERET in a taken cycle is squashed and its own PC pushed
  assign ret  = eret && !take && (stk_cnt != '0);

  always_comb begin
    pc_jump        = take | ret;
    interrupt      = take;
    writeback_mask = !take;
    pc_addr        = '0;
    if (take) begin
      pc_addr = ADDR_W'(vec_addr(EPC_W'(VEC_BASE), EPC_W'(VEC_STRIDE), LVL_W'(sel)));
    end else if (ret) begin
      pc_addr = ADDR_W'(stk_top.epc);
    end
  end

  assign stk_din = '{epc: EPC_W'(current_pc), level: LVL_W'(level_q)};

  epc_stack #(
    .W     ($bits(stk_ent_t)),
    .DEPTH (EFF_DEPTH)
  ) u_stack (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (take),
    .pop   (ret),
    .din   (stk_din),
    .top   (stk_top),
    .count (stk_cnt),
    .full  (stk_full)
  );

  always_comb begin
    clr_vec      = '0;
    clr_vec[sel] = take;
    irq_d        = irq;
    // a new edge on the line being taken survives the clear
    pend_d       = (pend_q & ~clr_vec) | (irq & ~irq_q);
    mask_d       = mask_we ? mask_wdata : mask_q;
    level_d      = level_q;
    if (take)     level_d = sel;
    else if (ret) level_d = SW'(stk_top.level);
    err_d        = err_q | (eret && !take && (stk_cnt == '0));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= MASK_RST;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      irq_q   <= irq_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  assign pending  = pend_q;
  assign depth    = DW'(stk_cnt);
  assign epc      = ADDR_W'(stk_top.epc);
  assign eret_err = err_q;

endmodule
